// File: rtl/cache_mem_pkg.sv
// cache_mem_pkg: shared types and sizing for the cache/memory arbitration path
package cache_mem_pkg;

    localparam int MEM_LATENCY       = 4;
    localparam int WORDS_PER_BLOCK   = 8;
    localparam int BLOCK_OFFSET_BITS = 4;
    localparam int WORD_IDX_BITS     = 3;

    typedef enum logic [1:0] {
        IDLE,
        FILL_I,
        FILL_D,
        STORE
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // Clears the byte offset so a fill always starts at word 0 of the block.
    function automatic logic [15:0] block_base(input logic [15:0] addr);
        return {addr[15:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache request, fill return and memory port signals of the arbiter
interface mem_arbiter_if;
    import cache_mem_pkg::*;

    logic                     i_miss;
    logic [15:0]              i_miss_addr;
    logic                     d_miss;
    logic [15:0]              d_miss_addr;
    logic                     d_wr_req;
    logic [15:0]              d_wr_addr;
    logic [15:0]              d_wr_data;
    logic                     mem_en;
    logic                     mem_wr;
    logic [15:0]              mem_addr;
    logic [15:0]              mem_wdata;
    logic [15:0]              mem_rdata;
    logic                     mem_data_valid;
    logic [15:0]              fill_data;
    logic [WORD_IDX_BITS-1:0] fill_word;
    logic                     i_fill_valid;
    logic                     d_fill_valid;
    logic                     i_fill_done;
    logic                     d_fill_done;
    logic                     d_wr_done;

    modport master (
        input  i_miss, i_miss_addr, d_miss, d_miss_addr,
        input  d_wr_req, d_wr_addr, d_wr_data,
        input  mem_rdata, mem_data_valid,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        output fill_data, fill_word, i_fill_valid, d_fill_valid,
        output i_fill_done, d_fill_done, d_wr_done
    );

    modport slave (
        output i_miss, i_miss_addr, d_miss, d_miss_addr,
        output d_wr_req, d_wr_addr, d_wr_data,
        output mem_rdata, mem_data_valid,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        input  fill_data, fill_word, i_fill_valid, d_fill_valid,
        input  i_fill_done, d_fill_done, d_wr_done
    );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between I/D block fills and D write-through stores
module mem_arbiter
    import cache_mem_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.master bus
);

    localparam int IC_W = WORD_IDX_BITS + 1;

    state_t                   state;
    grant_t                   last_grant;
    logic [15:0]              base;
    logic [IC_W-1:0]          ic;
    logic [WORD_IDX_BITS-1:0] rc;
    logic                     filling;
    logic                     issuing;
    logic                     returning;
    logic                     last_word;

    assign filling   = state == FILL_I || state == FILL_D;
    assign issuing   = filling && ic < IC_W'(WORDS_PER_BLOCK);
    assign returning = filling && bus.mem_data_valid;
    assign last_word = returning && rc == WORD_IDX_BITS'(WORDS_PER_BLOCK - 1);

    // Arbitration in IDLE only; a fill ends when its last word returns, then the other cache wins ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
            base       <= '0;
            ic         <= '0;
            rc         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ic <= '0;
                    rc <= '0;
                    if (bus.d_wr_req) begin
                        state <= STORE;
                    end else if (bus.d_miss && (!bus.i_miss || last_grant == GRANT_I)) begin
                        state <= FILL_D;
                        base  <= block_base(bus.d_miss_addr);
                    end else if (bus.i_miss) begin
                        state <= FILL_I;
                        base  <= block_base(bus.i_miss_addr);
                    end
                end
                FILL_I, FILL_D: begin
                    if (issuing) ic <= ic + 1'b1;
                    if (returning) rc <= rc + 1'b1;
                    if (last_word) begin
                        state      <= IDLE;
                        last_grant <= state == FILL_D ? GRANT_D : GRANT_I;
                    end
                end
                STORE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory port and fill return decoded from state and counters; returned words pass straight through.
    always_comb begin
        bus.mem_en       = issuing || state == STORE;
        bus.mem_wr       = state == STORE;
        bus.mem_addr     = state == STORE ? bus.d_wr_addr
                         : issuing ? base + 16'({ic[WORD_IDX_BITS-1:0], 1'b0}) : '0;
        bus.mem_wdata    = state == STORE ? bus.d_wr_data : '0;
        bus.fill_data    = returning ? bus.mem_rdata : '0;
        bus.fill_word    = returning ? rc : '0;
        bus.i_fill_valid = returning && state == FILL_I;
        bus.d_fill_valid = returning && state == FILL_D;
        bus.i_fill_done  = last_word && state == FILL_I;
        bus.d_fill_done  = last_word && state == FILL_D;
        bus.d_wr_done    = state == STORE;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of fills, stores, arbitration and reset against a fixed-latency memory
module tb_mem_arbiter;
    import cache_mem_pkg::*;

    localparam logic [15:0] PAT = 16'hC3A5;

    logic clk;
    logic rst_n;
    int   n_run;
    int   n_fail;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [MEM_LATENCY-1:0] vp;
    logic [15:0]            ap [MEM_LATENCY];

    // Memory model: each read returns addr^PAT exactly MEM_LATENCY cycles after issue.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vp <= '0;
            for (int k = 0; k < MEM_LATENCY; k++) ap[k] <= '0;
        end else begin
            vp    <= {vp[MEM_LATENCY-2:0], bus.mem_en && !bus.mem_wr};
            ap[0] <= bus.mem_addr;
            for (int k = 1; k < MEM_LATENCY; k++) ap[k] <= ap[k-1];
        end
    end

    assign bus.mem_data_valid = vp[MEM_LATENCY-1];
    assign bus.mem_rdata      = vp[MEM_LATENCY-1] ? ap[MEM_LATENCY-1] ^ PAT : 16'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returned data with no fill in progress is an error.
    always @(negedge clk) begin
        if (rst_n) check("stray_valid", 32'(bus.mem_data_valid && !(bus.i_fill_valid || bus.d_fill_valid)), 0);
    end

    task automatic check_zero(input string tag);
        check({tag, "_en"}, bus.mem_en, 0);
        check({tag, "_wr"}, bus.mem_wr, 0);
        check({tag, "_addr"}, bus.mem_addr, 0);
        check({tag, "_wdata"}, bus.mem_wdata, 0);
        check({tag, "_fdata"}, bus.fill_data, 0);
        check({tag, "_fword"}, bus.fill_word, 0);
        check({tag, "_ivld"}, bus.i_fill_valid, 0);
        check({tag, "_dvld"}, bus.d_fill_valid, 0);
        check({tag, "_idone"}, bus.i_fill_done, 0);
        check({tag, "_ddone"}, bus.d_fill_done, 0);
        check({tag, "_wdone"}, bus.d_wr_done, 0);
    endtask

    // Called in the IDLE cycle that sees the request (cycle 0); checks cycles 1..12 and drops the request.
    task automatic expect_fill(input bit dside, input logic [15:0] base);
        logic [15:0] ra;
        logic [15:0] wa;
        bit          vld;
        for (int c = 1; c <= 12; c++) begin
            tick();
            ra  = base + 16'(2 * (c - 1));
            wa  = base + 16'(2 * (c - 5));
            vld = c >= 5;
            check($sformatf("fill%0h_c%0d_en", base, c), bus.mem_en, 32'(c <= 8));
            check($sformatf("fill%0h_c%0d_wr", base, c), bus.mem_wr, 0);
            check($sformatf("fill%0h_c%0d_addr", base, c), bus.mem_addr, c <= 8 ? ra : 16'h0);
            check($sformatf("fill%0h_c%0d_ivld", base, c), bus.i_fill_valid, 32'(vld && !dside));
            check($sformatf("fill%0h_c%0d_dvld", base, c), bus.d_fill_valid, 32'(vld && dside));
            check($sformatf("fill%0h_c%0d_word", base, c), bus.fill_word, vld ? 32'(c - 5) : 0);
            check($sformatf("fill%0h_c%0d_data", base, c), bus.fill_data, vld ? wa ^ PAT : 16'h0);
            check($sformatf("fill%0h_c%0d_idone", base, c), bus.i_fill_done, 32'(c == 12 && !dside));
            check($sformatf("fill%0h_c%0d_ddone", base, c), bus.d_fill_done, 32'(c == 12 && dside));
            check($sformatf("fill%0h_c%0d_wdone", base, c), bus.d_wr_done, 0);
        end
        if (dside) bus.d_miss = 1'b0;
        else bus.i_miss = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_run           = 0;
        n_fail          = 0;
        rst_n           = 1'b0;
        bus.i_miss      = 1'b0;
        bus.i_miss_addr = '0;
        bus.d_miss      = 1'b0;
        bus.d_miss_addr = '0;
        bus.d_wr_req    = 1'b0;
        bus.d_wr_addr   = '0;
        bus.d_wr_data   = '0;
        repeat (2) tick();
        check_zero("reset");
        rst_n = 1'b1;
        // Lone I miss, then a D miss raised at the done pulse is granted at 13 and issued at 14.
        bus.i_miss      = 1'b1;
        bus.i_miss_addr = 16'h1236;
        check("t1_c0_en", bus.mem_en, 0);
        expect_fill(1'b0, 16'h1230);
        bus.d_miss      = 1'b1;
        bus.d_miss_addr = 16'h2004;
        tick();
        check("t1_c13_en", bus.mem_en, 0);
        expect_fill(1'b1, 16'h2000);
        tick();
        // Lone write-through store.
        bus.d_wr_req  = 1'b1;
        bus.d_wr_addr = 16'h0040;
        bus.d_wr_data = 16'hBEEF;
        check("st_c0_en", bus.mem_en, 0);
        tick();
        check("st_c1_en", bus.mem_en, 1);
        check("st_c1_wr", bus.mem_wr, 1);
        check("st_c1_addr", bus.mem_addr, 16'h0040);
        check("st_c1_wdata", bus.mem_wdata, 16'hBEEF);
        check("st_c1_done", bus.d_wr_done, 1);
        bus.d_wr_req = 1'b0;
        tick();
        check("st_c2_en", bus.mem_en, 0);
        check("st_c2_done", bus.d_wr_done, 0);
        // Simultaneous misses from reset alternate D, I, D, I.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int r = 0; r < 2; r++) begin
            bus.i_miss      = 1'b1;
            bus.i_miss_addr = 16'h3000;
            bus.d_miss      = 1'b1;
            bus.d_miss_addr = 16'h4000;
            expect_fill(1'b1, 16'h4000);
            tick();
            check($sformatf("tie%0d_idle_en", r), bus.mem_en, 0);
            expect_fill(1'b0, 16'h3000);
            tick();
        end
        // Store and D miss arrive during an I fill; store waits, then beats the D miss.
        bus.i_miss      = 1'b1;
        bus.i_miss_addr = 16'h6000;
        fork
            expect_fill(1'b0, 16'h6000);
            begin
                repeat (3) tick();
                bus.d_wr_req    = 1'b1;
                bus.d_wr_addr   = 16'h0050;
                bus.d_wr_data   = 16'h1234;
                bus.d_miss      = 1'b1;
                bus.d_miss_addr = 16'h5006;
            end
        join
        tick();
        check("pend_c13_en", bus.mem_en, 0);
        check("pend_c13_wdone", bus.d_wr_done, 0);
        tick();
        check("pend_c14_en", bus.mem_en, 1);
        check("pend_c14_wr", bus.mem_wr, 1);
        check("pend_c14_addr", bus.mem_addr, 16'h0050);
        check("pend_c14_wdata", bus.mem_wdata, 16'h1234);
        check("pend_c14_wdone", bus.d_wr_done, 1);
        bus.d_wr_req = 1'b0;
        tick();
        check("pend_c15_en", bus.mem_en, 0);
        expect_fill(1'b1, 16'h5000);
        tick();
        // Reset at cycle 7 of a D fill aborts it; the fill restarts from word 0 after release.
        bus.d_miss      = 1'b1;
        bus.d_miss_addr = 16'h7008;
        repeat (7) tick();
        check("rst_c7_en", bus.mem_en, 1);
        check("rst_c7_addr", bus.mem_addr, 16'h700C);
        check("rst_c7_dvld", bus.d_fill_valid, 1);
        check("rst_c7_word", bus.fill_word, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        repeat (2) tick();
        check_zero("rst_hold");
        rst_n = 1'b1;
        expect_fill(1'b1, 16'h7000);
        tick();
        // Top-of-memory block must not wrap.
        bus.d_miss      = 1'b1;
        bus.d_miss_addr = 16'hFFF2;
        expect_fill(1'b1, 16'hFFF0);
        tick();
        check_zero("end");
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
